alu_share_ctrl: RTL and testbench

//  Shares the single combinational 32-bit ALU (ADD/SUB/AND/ORR, NZCV flags) between NREQ requesters.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_share_ctrl_if.sv | 38 +++
 rtl/rr_arb.sv | 40 ++++
 rtl/alu_share_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ALU, the instruction decoder and alu_share_ctrl.
//   - ALU op codes (2-bit alu_control encoding)
//   - NZCV flag bit positions inside the 4-bit flag vector
//   - alu_share_ctrl FSM state type
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } share_state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl_if
// Request/response bundle between NREQ requesters and alu_share_ctrl.
//   req_valid/req_ready [NREQ]     request handshake, one bit per requester
//   req_a/req_b         [NREQ*W]   operands, slice i = [i*W +: W]
//   req_op              [NREQ*2]   op code, slice i = [i*2 +: 2]
//   req_setf            [NREQ]     op updates the NZCV register (optional)
//   rsp_valid/rsp_ready [NREQ]     response handshake, one-hot or zero
//   rsp_result [W], rsp_flags [4]  shared response bus, qualify with rsp_valid
// Modports: master = requester side, slave = alu_share_ctrl side.
// ---------------------------------------------------------------------------
interface alu_share_ctrl_if #(
  parameter int W    = 32,
  parameter int NREQ = 2
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*2-1:0] req_op;
  logic [NREQ-1:0]   req_setf;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_result;
  logic [3:0]        rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op, req_setf, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_setf, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );

endinterface

// File: rtl/rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
// Combinational round-robin pick. Searches req starting at index ptr and
// wrapping modulo N; the first set bit wins.
//   req [N]   in   request bits
//   ptr [IW]  in   index with highest priority this cycle
//   gnt [N]   out  one-hot grant (zero when no request)
//   idx [IW]  out  index of the granted requester (0 when none)
//   any       out  at least one request present
// ---------------------------------------------------------------------------
module rr_arb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < N; k++) begin
      // Candidate position k steps after ptr, wrapped without a modulo op.
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
// Time-shares one external combinational ALU between NREQ requesters.
// A round-robin winner is accepted in IDLE, its operands are registered and
// drive the ALU during EXEC, the ALU result/flags are captured at the end of
// EXEC and presented on the winner's response channel in RESP until taken.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   bus (slave)         request/response bundle, see alu_share_ctrl_if
//   alu_src_a/_b [W]    ALU operands (always from the operand registers)
//   alu_control [2]     ALU op select
//   alu_result [W]      ALU result
//   alu_flags [4]       ALU {N,Z,C,V}
//   busy                high in EXEC and RESP
//   nzcv [4]            architectural flag register (ALU_SHARE_NZCV_REG_EN only)
//
// Configuration
//   ALU_SHARE_NZCV_REG_EN  when defined, adds the nzcv output; it loads the
//                          captured flags on a response handshake whose
//                          request had setf=1. When undefined, req_setf is
//                          ignored.
// ---------------------------------------------------------------------------
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int W    = 32,
  parameter int NREQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_share_ctrl_if.slave  bus,
  output logic [W-1:0]     alu_src_a,
  output logic [W-1:0]     alu_src_b,
  output logic [1:0]       alu_control,
  input  logic [W-1:0]     alu_result,
  input  logic [3:0]       alu_flags,
  output logic             busy
`ifdef ALU_SHARE_NZCV_REG_EN
  ,
  output logic [3:0]       nzcv
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  share_state_e  state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gidx_q;
  logic [W-1:0]  a_q, b_q, res_q;
  logic [1:0]    op_q;
  logic [3:0]    flags_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            accept;
  logic            rsp_hs;

  // Per-requester views of the flattened payload buses.
  logic [W-1:0] a_arr  [NREQ];
  logic [W-1:0] b_arr  [NREQ];
  logic [1:0]   op_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi]  = bus.req_a[gi*W +: W];
    assign b_arr[gi]  = bus.req_b[gi*W +: W];
    assign op_arr[gi] = bus.req_op[gi*2 +: 2];
  end

  rr_arb #(
    .N  (NREQ),
    .IW (IW)
  ) u_arb (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Ready only in IDLE, so no new grant can appear while an op is in flight.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_hs
    assign bus.req_ready[gi] = (state_q == S_IDLE) && arb_gnt[gi];
    assign bus.rsp_valid[gi] = (state_q == S_RESP) && (gidx_q == IW'(gi));
  end

  // Response bus is driven straight from the capture registers so it stays
  // stable for as long as the response is stalled.
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flags_q;

  // ALU inputs come only from registers: stable outside EXEC, no glitches.
  assign alu_src_a   = a_q;
  assign alu_src_b   = b_q;
  assign alu_control = op_q;

  assign busy = (state_q != S_IDLE);

  // Priority moves to the requester after the one just served.
  assign ptr_d = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rsp_hs  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          accept  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready[gidx_q]) begin
          rsp_hs  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      gidx_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      if (accept) begin
        a_q    <= a_arr[arb_idx];
        b_q    <= b_arr[arb_idx];
        op_q   <= op_arr[arb_idx];
        gidx_q <= arb_idx;
      end
      if (state_q == S_EXEC) begin
        res_q   <= alu_result;
        flags_q <= alu_flags;
      end
      if (rsp_hs) begin
        ptr_q <= ptr_d;
      end
    end
  end

`ifdef ALU_SHARE_NZCV_REG_EN
  logic [3:0] nzcv_q;
  logic       setf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      setf_q <= 1'b0;
      nzcv_q <= 4'b0000;
    end else begin
      if (accept) begin
        setf_q <= bus.req_setf[arb_idx];
      end
      if (rsp_hs && setf_q) begin
        nzcv_q <= flags_q;
      end
    end
  end

  assign nzcv = nzcv_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_share_ctrl
// Directed bench for alu_share_ctrl with a behavioural ALU attached.
// Table of single-requester vectors plus hand-written sequences for
// contention, response stall, mid-operation reset, NZCV register
// (ALU_SHARE_NZCV_REG_EN) and back-to-back issue.
// ---------------------------------------------------------------------------
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int W    = 32;
  localparam int NREQ = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_src_a, alu_src_b, alu_result;
  logic [1:0]  alu_control;
  logic [3:0]  alu_flags;
  logic        busy;
`ifdef ALU_SHARE_NZCV_REG_EN
  logic [3:0]  nzcv;
`endif

  int tests;
  int fails;

  alu_share_ctrl_if #(.W(W), .NREQ(NREQ)) bus_if ();

  alu_share_ctrl #(.W(W), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if.slave),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .busy        (busy)
`ifdef ALU_SHARE_NZCV_REG_EN
    ,
    .nzcv        (nzcv)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: ARM-style flags, C on SUB means "no borrow".
  function automatic logic [35:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic [3:0]  f;
    s = '0;
    f = '0;
    case (op)
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        f[FLAG_C] = s[32];
        f[FLAG_V] = (a[31] == b[31]) && (r[31] != a[31]);
      end
      ALU_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[31:0];
        f[FLAG_C] = ~s[32];
        f[FLAG_V] = (a[31] != b[31]) && (r[31] != a[31]);
      end
      ALU_AND: r = a & b;
      default: r = a | b;
    endcase
    f[FLAG_N] = r[31];
    f[FLAG_Z] = (r == 32'd0);
    return {f, r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_src_a, alu_src_b, alu_control);

  typedef struct {
    int          g;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t vt[7];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(int g, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic setf);
    bus_if.req_a[g*W +: W] = a;
    bus_if.req_b[g*W +: W] = b;
    bus_if.req_op[g*2 +: 2] = op;
    bus_if.req_setf[g]      = setf;
    bus_if.req_valid[g]     = 1'b1;
  endtask

  // Called at a falling edge in IDLE with the payload already applied.
  // Checks grant, EXEC, RESP (2 cycles after accept) and the return to IDLE.
  task automatic serve(int g, logic [31:0] er, logic [3:0] ef, string tag);
    logic [1:0] oh;
    oh = 2'b01 << g;
    #1;
    chk({tag, ".req_ready"}, bus_if.req_ready, oh);
    chk({tag, ".busy_idle"}, busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid[g] = 1'b0;
    #1;
    chk({tag, ".busy_exec"}, busy, 1'b1);
    chk({tag, ".rsp_valid_exec"}, bus_if.rsp_valid, 2'b00);
    chk({tag, ".ready_exec"}, bus_if.req_ready, 2'b00);
    @(negedge clk);
    #1;
    chk({tag, ".rsp_valid"}, bus_if.rsp_valid, oh);
    chk({tag, ".result"}, bus_if.rsp_result, er);
    chk({tag, ".flags"}, bus_if.rsp_flags, ef);
    $display("[TB] %s req%0d result=%08h flags=%04b", tag, g, bus_if.rsp_result, bus_if.rsp_flags);
    bus_if.rsp_ready[g] = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready[g] = 1'b0;
    #1;
    chk({tag, ".rsp_valid_after"}, bus_if.rsp_valid, 2'b00);
    chk({tag, ".busy_after"}, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    vt[0] = '{0, ALU_ADD, 32'd5,        32'd7,        32'd12,       4'b0000};
    vt[1] = '{1, ALU_SUB, 32'd3,        32'd3,        32'd0,        4'b0110};
    vt[2] = '{0, ALU_ADD, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b0110};
    vt[3] = '{1, ALU_ADD, 32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b1001};
    vt[4] = '{0, ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000};
    vt[5] = '{1, ALU_ORR, 32'h80000000, 32'd0,        32'h80000000, 4'b1000};
    vt[6] = '{0, ALU_SUB, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b1000};

    rst_n            = 1'b0;
    bus_if.req_valid = '0;
    bus_if.req_a     = '0;
    bus_if.req_b     = '0;
    bus_if.req_op    = '0;
    bus_if.req_setf  = '0;
    bus_if.rsp_ready = '0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst.busy", busy, 1'b0);
    chk("rst.rsp_valid", bus_if.rsp_valid, 2'b00);
    chk("rst.req_ready", bus_if.req_ready, 2'b00);
    chk("rst.alu_src_a", alu_src_a, 32'd0);
    chk("rst.alu_control", alu_control, 2'd0);
    chk("rst.rsp_result", bus_if.rsp_result, 32'd0);
    chk("rst.rsp_flags", bus_if.rsp_flags, 4'd0);
`ifdef ALU_SHARE_NZCV_REG_EN
    chk("rst.nzcv", nzcv, 4'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention after reset: ptr=0 so req0 first, then alternation.
    set_req(0, ALU_ADD, 32'd1, 32'd2, 1'b0);
    set_req(1, ALU_ADD, 32'd10, 32'd20, 1'b0);
    serve(0, 32'd3, 4'b0000, "cont0");
    set_req(0, ALU_ADD, 32'd1, 32'd2, 1'b0);
    serve(1, 32'd30, 4'b0000, "cont1");
    set_req(1, ALU_ADD, 32'd10, 32'd20, 1'b0);
    serve(0, 32'd3, 4'b0000, "cont2");
    serve(1, 32'd30, 4'b0000, "cont3");

    // Single-requester vectors
    for (int i = 0; i < 7; i++) begin
      set_req(vt[i].g, vt[i].op, vt[i].a, vt[i].b, 1'b0);
      serve(vt[i].g, vt[i].res, vt[i].fl, $sformatf("vec%0d", i));
    end

    // Response stall: req1 SUB 3-3 held in RESP for 5 cycles, req0 waits.
    set_req(1, ALU_SUB, 32'd3, 32'd3, 1'b0);
    #1;
    chk("stall.req_ready", bus_if.req_ready, 2'b10);
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid[1] = 1'b0;
    set_req(0, ALU_ADD, 32'd100, 32'd200, 1'b0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall.rsp_valid", bus_if.rsp_valid, 2'b10);
      chk("stall.result", bus_if.rsp_result, 32'd0);
      chk("stall.flags", bus_if.rsp_flags, 4'b0110);
      chk("stall.busy", busy, 1'b1);
      chk("stall.req_ready", bus_if.req_ready, 2'b00);
      @(negedge clk);
    end
    $display("[TB] stall req1 result=%08h flags=%04b", bus_if.rsp_result, bus_if.rsp_flags);
    bus_if.rsp_ready[1] = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready[1] = 1'b0;
    serve(0, 32'd300, 4'b0000, "after_stall");

    // Reset during EXEC (ptr=1 beforehand): op dropped, ptr back to 0.
    set_req(0, ALU_ADD, 32'd9, 32'd9, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid[0] = 1'b0;
    #1;
    chk("mid_rst.busy_exec", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.busy", busy, 1'b0);
    chk("mid_rst.rsp_valid", bus_if.rsp_valid, 2'b00);
    chk("mid_rst.alu_src_a", alu_src_a, 32'd0);
    chk("mid_rst.rsp_result", bus_if.rsp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("mid_rst.no_rsp", bus_if.rsp_valid, 2'b00);
    end
    $display("[TB] mid-op reset done");
    set_req(0, ALU_ADD, 32'd2, 32'd2, 1'b0);
    set_req(1, ALU_ADD, 32'd5, 32'd5, 1'b0);
    serve(0, 32'd4, 4'b0000, "post_rst0");
    serve(1, 32'd10, 4'b0000, "post_rst1");

`ifdef ALU_SHARE_NZCV_REG_EN
    set_req(0, ALU_ORR, 32'h80000000, 32'd0, 1'b1);
    serve(0, 32'h80000000, 4'b1000, "nzcv_orr");
    chk("nzcv.orr_setf", nzcv, 4'b1000);
    set_req(0, ALU_AND, 32'h0000000F, 32'h000000F0, 1'b0);
    serve(0, 32'd0, 4'b0100, "nzcv_and");
    chk("nzcv.and_hold", nzcv, 4'b1000);
    set_req(1, ALU_ADD, 32'd0, 32'd0, 1'b1);
    serve(1, 32'd0, 4'b0100, "nzcv_add");
    chk("nzcv.add_setf", nzcv, 4'b0100);
`endif

    // Back-to-back from req0 with rsp_ready tied high: accept every 3 cycles.
    bus_if.rsp_ready[0] = 1'b1;
    set_req(0, ALU_ADD, 32'd1, 32'd1, 1'b0);
    for (int c = 0; c < 9; c++) begin
      #1;
      chk($sformatf("b2b.ready_c%0d", c), bus_if.req_ready, (c % 3 == 0) ? 2'b01 : 2'b00);
      chk($sformatf("b2b.rsp_c%0d", c), bus_if.rsp_valid, (c % 3 == 2) ? 2'b01 : 2'b00);
      if (c % 3 == 2) begin
        chk($sformatf("b2b.result_c%0d", c), bus_if.rsp_result, 32'd2);
        $display("[TB] b2b req0 cycle %0d result=%08h", c, bus_if.rsp_result);
      end
      @(negedge clk);
    end
    bus_if.req_valid = '0;
    bus_if.rsp_ready = '0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
